// File: rtl/i2s_codec_if_if.sv
// Core-side sample bus of the I2S codec interface: tx pair with ready/valid
// holding handshake, rx pair with a single-cycle valid strobe.
interface i2s_codec_if_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tx_left;
    logic [DATA_W-1:0] tx_right;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_underrun;
    logic [DATA_W-1:0] rx_left;
    logic [DATA_W-1:0] rx_right;
    logic              rx_valid;

    modport master (
        output tx_left, tx_right, tx_valid,
        input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );

    modport slave (
        input  tx_left, tx_right, tx_valid,
        output tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );
endinterface

// File: rtl/i2s_codec_if.sv
// I2S master: MCLK/SCLK/LRCLK generation, codec reset sequencing, stereo tx/rx.
// Define I2S_CODEC_IF_UNDERRUN_MUTE_EN to send 0/0 instead of repeating on underrun.
module i2s_codec_if #(
    parameter int DATA_W        = 16,
    parameter int BITS_PER_SLOT = 16,
    parameter int SCLK_HALF     = 16,
    parameter int MCLK_DIV_LOG2 = 2,
    parameter int RST_FRAMES    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    i2s_codec_if_if.slave core,
    input  logic          sd_from_codec,
    output logic          sd_to_codec,
    output logic          mclk,
    output logic          sclk,
    output logic          lrclk,
    output logic          codec_rst_n
);
    // state        | meaning
    // ST_CODEC_RST | codec held in reset, counting frame starts
    // ST_SETTLE    | codec released, first clean frame still being captured
    // ST_RUN       | received pairs are reported

    localparam int FRAME_BITS = 2 * BITS_PER_SLOT;
    localparam int P_W        = $clog2(2 * SCLK_HALF);
    localparam int K_W        = $clog2(FRAME_BITS);
    localparam int FC_W       = $clog2(RST_FRAMES + 1);

    localparam logic [P_W-1:0]  P_LAST  = P_W'(2 * SCLK_HALF - 1);
    localparam logic [P_W-1:0]  P_RISE  = P_W'(SCLK_HALF);
    localparam logic [P_W-1:0]  P_PRE   = P_W'(SCLK_HALF - 1);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(FRAME_BITS - 1);
    localparam logic [K_W-1:0]  K_RIGHT = K_W'(BITS_PER_SLOT);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(RST_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_CODEC_RST,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t state, state_nxt;

    logic [P_W-1:0]           p, p_nxt;
    logic [K_W-1:0]           k, k_nxt;
    logic [MCLK_DIV_LOG2-1:0] mcnt;
    logic [FC_W-1:0]          fcnt;
    logic                     bit_end, frame_start, rx_sample;

    logic [DATA_W-1:0]     hold_l, hold_r, prev_l, prev_r, load_l, load_r;
    logic                  hold_empty, tx_hs, underrun_q, sd_q;
    logic [FRAME_BITS-1:0] tx_sr, load_frame;

    logic [FRAME_BITS-1:0] rx_sr;
    logic [DATA_W-1:0]     rx_l, rx_r;
    logic                  rx_done, rx_valid_q;

    assign bit_end     = (p == P_LAST);
    assign frame_start = bit_end && (k == K_LAST);
    assign rx_sample   = (p == P_PRE);

    always_comb begin
        p_nxt = p + P_W'(1);
        k_nxt = k;
        if (bit_end) begin
            p_nxt = '0;
            k_nxt = (k == K_LAST) ? '0 : k + K_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p     <= '0;
            k     <= '0;
            mcnt  <= '0;
            sclk  <= 1'b0;
            lrclk <= 1'b0;
        end else begin
            p     <= p_nxt;
            k     <= k_nxt;
            mcnt  <= mcnt + MCLK_DIV_LOG2'(1);
            sclk  <= (p_nxt >= P_RISE);
            lrclk <= (k_nxt >= K_RIGHT);
        end
    end

    assign mclk = mcnt[MCLK_DIV_LOG2-1];

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            case (state)
                ST_CODEC_RST: if (fcnt == FC_LAST) state_nxt = ST_SETTLE;
                ST_SETTLE:    state_nxt = ST_RUN;
                default:      state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CODEC_RST;
            fcnt        <= '0;
            codec_rst_n <= 1'b0;
        end else begin
            state       <= state_nxt;
            codec_rst_n <= (state_nxt != ST_CODEC_RST);
            if (frame_start && state == ST_CODEC_RST) fcnt <= fcnt + FC_W'(1);
        end
    end

    assign tx_hs = core.tx_valid && hold_empty;

    always_comb begin
`ifdef I2S_CODEC_IF_UNDERRUN_MUTE_EN
        load_l = hold_empty ? '0 : hold_l;
        load_r = hold_empty ? '0 : hold_r;
`else
        load_l = hold_empty ? prev_l : hold_l;
        load_r = hold_empty ? prev_r : hold_r;
`endif
        load_frame = '0;
        load_frame[FRAME_BITS-1 -: DATA_W]    = load_l;
        load_frame[BITS_PER_SLOT-1 -: DATA_W] = load_r;
    end

    // Period 0 of a frame still carries the previous frame's right LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_l     <= '0;
            hold_r     <= '0;
            prev_l     <= '0;
            prev_r     <= '0;
            hold_empty <= 1'b1;
            tx_sr      <= '0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (frame_start) begin
                sd_q       <= tx_sr[FRAME_BITS-1];
                tx_sr      <= load_frame;
                prev_l     <= load_l;
                prev_r     <= load_r;
                underrun_q <= hold_empty;
            end else if (bit_end) begin
                sd_q  <= tx_sr[FRAME_BITS-1];
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
            end
            if (frame_start && !hold_empty) begin
                hold_empty <= 1'b1;
            end else if (tx_hs) begin
                hold_l     <= core.tx_left;
                hold_r     <= core.tx_right;
                hold_empty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr      <= '0;
            rx_done    <= 1'b0;
            rx_l       <= '0;
            rx_r       <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            rx_valid_q <= 1'b0;
            if (rx_sample) begin
                rx_sr   <= {rx_sr[FRAME_BITS-2:0], sd_from_codec};
                rx_done <= (k == '0);
            end
            if (rx_done && state == ST_RUN) begin
                rx_l       <= rx_sr[FRAME_BITS-1 -: DATA_W];
                rx_r       <= rx_sr[BITS_PER_SLOT-1 -: DATA_W];
                rx_valid_q <= 1'b1;
            end
        end
    end

    assign sd_to_codec      = sd_q;
    assign core.tx_ready    = hold_empty;
    assign core.tx_underrun = underrun_q;
    assign core.rx_left     = rx_l;
    assign core.rx_right    = rx_r;
    assign core.rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_i2s_codec_if.sv
// Bench for i2s_codec_if: default instance driven by a modelled codec, plus a
// 12-bit instance with its serial data looped back.
module tb_i2s_codec_if;
    localparam int SH        = 16;
    localparam int BIT_CLK   = 2 * SH;
    localparam int FRAME_CLK = 32 * BIT_CLK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_codec_if_if #(.DATA_W(16)) bus ();
    i2s_codec_if_if #(.DATA_W(12)) bus12 ();

    logic sd_from_codec, sd_to_codec, mclk, sclk, lrclk, codec_rst_n;
    logic sd12, mclk12, sclk12, lrclk12, codec_rst_n12;

    i2s_codec_if dut (
        .clk(clk), .rst_n(rst_n), .core(bus),
        .sd_from_codec(sd_from_codec), .sd_to_codec(sd_to_codec),
        .mclk(mclk), .sclk(sclk), .lrclk(lrclk), .codec_rst_n(codec_rst_n)
    );

    i2s_codec_if #(.DATA_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .core(bus12),
        .sd_from_codec(sd12), .sd_to_codec(sd12),
        .mclk(mclk12), .sclk(sclk12), .lrclk(lrclk12), .codec_rst_n(codec_rst_n12)
    );

    assign bus12.tx_left  = 12'hABC;
    assign bus12.tx_right = 12'h5A3;
    assign bus12.tx_valid = 1'b1;

    int errors = 0;
    int checks = 0;
    int c;

    logic        m_empty, exp_underrun;
    logic [15:0] hold_l, hold_r, prev_l, prev_r, cur_l, cur_r, last_l, last_r;
    logic [15:0] q_l[$], q_r[$];
    logic [15:0] src_l[0:15], src_r[0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at c=%0d", tag, obs, exp, c);
        end
    endtask

    // Frame bit j (0 = left MSB) of a pair whose samples are w bits wide.
    function automatic logic frame_bit(input logic [15:0] l, input logic [15:0] r,
                                       input int j, input int w);
        logic [15:0] s;
        int pos;
        s   = (j < 16) ? l : r;
        pos = j % 16;
        if (pos >= w) return 1'b0;
        return s[w-1-pos];
    endfunction

    function automatic logic codec_bit(input int cc);
        int f, k;
        f = cc / FRAME_CLK;
        k = (cc / BIT_CLK) % 32;
        if (k == 0) return (f == 0) ? 1'b0 : frame_bit(src_l[f-1], src_r[f-1], 31, 16);
        return frame_bit(src_l[f], src_r[f], k - 1, 16);
    endfunction

    task automatic drive_tx();
        bus.tx_valid = (q_l.size() > 0);
        bus.tx_left  = (q_l.size() > 0) ? q_l[0] : 16'h0;
        bus.tx_right = (q_r.size() > 0) ? q_r[0] : 16'h0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        q_l.push_back(l);
        q_r.push_back(r);
        drive_tx();
    endtask

    task automatic model_reset();
        m_empty = 1'b1;
        exp_underrun = 1'b0;
        {hold_l, hold_r, prev_l, prev_r, cur_l, cur_r, last_l, last_r} = '0;
    endtask

    task automatic reset_checks(input string p);
        chk({p, "sclk"}, sclk, 0);
        chk({p, "lrclk"}, lrclk, 0);
        chk({p, "mclk"}, mclk, 0);
        chk({p, "sd_to_codec"}, sd_to_codec, 0);
        chk({p, "tx_underrun"}, bus.tx_underrun, 0);
        chk({p, "rx_valid"}, bus.rx_valid, 0);
        chk({p, "tx_ready"}, bus.tx_ready, 1);
        chk({p, "rx_left"}, bus.rx_left, 0);
        chk({p, "rx_right"}, bus.rx_right, 0);
        chk({p, "codec_rst_n"}, codec_rst_n, 0);
        chk({p, "sd12"}, sd12, 0);
        chk({p, "rx_valid12"}, bus12.rx_valid, 0);
    endtask

    task automatic tick();
        logic        hs, fs, rv, exp_sd, exp_sd12;
        logic [15:0] in_l, in_r;
        int          f, k;
        hs   = bus.tx_valid && m_empty;
        in_l = bus.tx_left;
        in_r = bus.tx_right;
        @(posedge clk);
        #1;
        c++;
        fs = (c % FRAME_CLK == 0);
        exp_underrun = 1'b0;
        if (fs) begin
            last_l = cur_l;
            last_r = cur_r;
            if (!m_empty) begin
                cur_l = hold_l;  cur_r = hold_r;
                prev_l = hold_l; prev_r = hold_r;
                m_empty = 1'b1;
            end else begin
                exp_underrun = 1'b1;
`ifdef I2S_CODEC_IF_UNDERRUN_MUTE_EN
                prev_l = '0; prev_r = '0;
`endif
                cur_l = prev_l; cur_r = prev_r;
            end
        end
        if (hs) begin
            hold_l = in_l; hold_r = in_r;
            m_empty = 1'b0;
            void'(q_l.pop_front());
            void'(q_r.pop_front());
        end
        drive_tx();
        sd_from_codec = codec_bit(c);

        f = c / FRAME_CLK;
        k = (c / BIT_CLK) % 32;
        exp_sd   = (k == 0) ? frame_bit(last_l, last_r, 31, 16) : frame_bit(cur_l, cur_r, k - 1, 16);
        exp_sd12 = (k == 0) ? ((f >= 2) ? frame_bit(16'hABC, 16'h5A3, 31, 12) : 1'b0)
                            : ((f >= 1) ? frame_bit(16'hABC, 16'h5A3, k - 1, 12) : 1'b0);
        rv = (c % FRAME_CLK == SH + 1) && (c >= 2 * FRAME_CLK);

        chk("sclk", sclk, (c % BIT_CLK) >= SH);
        chk("lrclk", lrclk, (c % FRAME_CLK) >= FRAME_CLK / 2);
        chk("mclk", mclk, (c % 4) >= 2);
        chk("codec_rst_n", codec_rst_n, c >= FRAME_CLK);
        chk("tx_ready", bus.tx_ready, m_empty);
        chk("tx_underrun", bus.tx_underrun, exp_underrun);
        chk("sd_to_codec", sd_to_codec, exp_sd);
        chk("rx_valid", bus.rx_valid, rv);
        if (rv) begin
            chk("rx_left", bus.rx_left, src_l[f-1]);
            chk("rx_right", bus.rx_right, src_r[f-1]);
        end

        chk("sclk12", sclk12, (c % BIT_CLK) >= SH);
        chk("lrclk12", lrclk12, (c % FRAME_CLK) >= FRAME_CLK / 2);
        chk("mclk12", mclk12, (c % 4) >= 2);
        chk("codec_rst_n12", codec_rst_n12, c >= FRAME_CLK);
        chk("tx_ready12", bus12.tx_ready, fs);
        chk("tx_underrun12", bus12.tx_underrun, 0);
        chk("sd12", sd12, exp_sd12);
        chk("rx_valid12", bus12.rx_valid, rv);
        if (rv) begin
            chk("rx_left12", bus12.rx_left, 12'hABC);
            chk("rx_right12", bus12.rx_right, 12'h5A3);
        end
    endtask

    task automatic run_until(input int target);
        while (c < target) tick();
    endtask

    initial begin
        c = 0;
        model_reset();
        sd_from_codec = 1'b0;
        drive_tx();
        for (int i = 0; i < 16; i++) begin
            src_l[i] = 16'($urandom);
            src_r[i] = 16'($urandom);
        end
        src_l[1] = 16'h1234;
        src_r[1] = 16'hFEDC;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_");

        @(negedge clk);
        rst_n = 1'b1;
        push(16'hA5C3, 16'h0F0F);
        run_until(FRAME_CLK + 200);

        // P1 goes straight into the holding register, P2 waits for the next frame start.
        push(16'($urandom), 16'($urandom));
        push(16'($urandom), 16'($urandom));
        run_until(4 * FRAME_CLK + 100);

        for (int f = 4; f < 10; f++) begin
            run_until(f * FRAME_CLK + int'($urandom_range(100, 900)));
            for (int n = int'($urandom_range(0, 2)); n > 0; n--)
                push(16'($urandom), 16'($urandom));
        end

        run_until(10 * FRAME_CLK + 529);
        push(16'($urandom), 16'($urandom));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("mid_");

        q_l.delete();
        q_r.delete();
        drive_tx();
        model_reset();
        c = 0;
        sd_from_codec = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_until(FRAME_CLK + 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2s_codec_if.md
# i2s_codec_if

Parametrised I2S master between the digital audio core and the external stereo codec. Generates MCLK, SCLK and LRCLK from `clk` and holds the codec in reset for a configurable number of frames. Serialises one stereo sample pair per frame to the DAC through a ready/valid holding register, and deserialises one ADC pair per frame with a single-cycle valid strobe. Transmit starvation is detected and reported.

## Interface
- `DATA_W`, 16: sample width on the core side; 8 ≤ DATA_W ≤ BITS_PER_SLOT.
- `BITS_PER_SLOT`, 16: SCLK periods per channel slot. A frame is 2·BITS_PER_SLOT bit periods.
- `SCLK_HALF`, 16: clk cycles per SCLK half-period; ≥ 2.
- `MCLK_DIV_LOG2`, 2: MCLK = clk / 2^MCLK_DIV_LOG2; ≥ 1.
- `RST_FRAMES`, 1: complete frames `codec_rst_n` is held low after reset; ≥ 1.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `tx_left`, `tx_right`  in  DATA_W  sample pair for DAC, two's complement
- `tx_valid`  in  1  tx pair offered
- `tx_ready`  out  1  holding register empty
- `tx_underrun`  out  1  1-clk pulse: frame started with holding register empty
- `sd_from_codec`  in  1  ADC serial data
- `sd_to_codec`  out  1  DAC serial data
- `rx_left`, `rx_right`  out  DATA_W  last received pair
- `rx_valid`  out  1  1-clk pulse: new rx pair
- `mclk`, `sclk`, `lrclk`  out  1  codec clocks
- `codec_rst_n`  out  1  codec reset, active-low

## Operation
- Free-running counters run from reset: phase p in 0..2·SCLK_HALF−1 and bit index k in 0..2·BITS_PER_SLOT−1. Both wrap.
- Clock outputs:
  - `sclk` = (p ≥ SCLK_HALF).
  - `lrclk` = (k ≥ BITS_PER_SLOT); low means left slot.
  - `mclk` = bit MCLK_DIV_LOG2−1 of a free-running clk counter.
- Frame start: the clk edge on which (p,k) wraps to (0,0). This is an SCLK falling edge together with an LRCLK falling edge.
- I2S one-bit delay, MSB first. In bit period k the line carries frame bit k−1. Period 0 carries bit 2·BITS_PER_SLOT−1 of the previous frame, which is the right LSB.
- Slot bit layout: sample in the top DATA_W bits; the lower BITS_PER_SLOT−DATA_W bits are 0 on tx and discarded on rx.
- TX holding register:
  - `tx_ready` is high when the register is empty.
  - Handshake `tx_valid && tx_ready` captures the pair and the register becomes full.
- TX frame load, at frame start:
  - Full: the pair moves to the shifter and the register becomes empty. `tx_ready` rises on the next clk.
  - Empty: underrun. `tx_underrun` pulses and the shifter reloads the previously sent pair (see Configuration).
  - Handshake on the same edge as a frame start with an empty register: the pair lands in the holding register, not in this frame. The underrun is still reported.
- Before the first accepted pair, the "previous pair" is 0/0.
- RX:
  - Sample `sd_from_codec` on the clk edge where p becomes SCLK_HALF (SCLK rising).
  - The right LSB is sampled in period 0 of the following frame.
  - On the next clk, `rx_left`/`rx_right` update and `rx_valid` pulses.
- Codec reset: `codec_rst_n` is low from reset and rises at frame start number RST_FRAMES, then stays high.
- `rx_valid` is suppressed until one complete frame has been captured with `codec_rst_n` high.
- Reset mid-frame: all counters, shifters and the holding register clear immediately and the frame restarts from (0,0). A pending tx pair is lost.

## Timing
- Reset values: `sclk`, `lrclk`, `mclk`, `sd_to_codec`, `tx_underrun`, `rx_valid` = 0; `tx_ready` = 1; `rx_left`, `rx_right` = 0; `codec_rst_n` = 0.
- Defaults give a 1024-clk frame, a 32-clk SCLK period and a 4-clk MCLK period. The first frame start is clk 1024 after reset release.
- All outputs are registered. `sd_to_codec` changes on the same clk edge as the `sclk` falling edge and is stable for one full SCLK period.
- TX latency: a pair accepted before frame start F appears as the left MSB in bit period 1 of frame F.
- RX latency: `rx_valid` asserts 1 clk after the right-LSB sampling edge, which is SCLK_HALF+1 clk after the next frame start.
- `tx_underrun` and `rx_valid` never exceed 1 clk. Back-to-back pulses occur only one frame apart.

## Configuration
- `I2S_CODEC_IF_UNDERRUN_MUTE_EN`
  - Defined: an underrun frame transmits 0/0 and the "previous pair" memory is cleared to 0.
  - Not defined: an underrun frame repeats the last transmitted pair.
  - `tx_underrun` behaves identically in both cases.

## Test plan
- Reset release, defaults -> `mclk` period 4 clk, `sclk` period 32, `lrclk` period 1024 with left slot first; `codec_rst_n` rises at clk 1024; `tx_ready`=1.
- Push tx 16'hA5C3/16'h0F0F before the first frame start -> on sclk rising edges of bit periods 1..16, `sd_to_codec` = A5C3 MSB-first; periods 17..31 plus next period 0 = 0F0F; no underrun.
- Drive `sd_from_codec` I2S-formatted 16'h1234/16'hFEDC -> `rx_valid` 1-clk pulse SCLK_HALF+1 clk after the next frame start with `rx_left`=1234, `rx_right`=FEDC; no pulse in the first post-reset frame.
- Hold `tx_valid` with pairs P1, P2 -> P1 accepted immediately; `tx_ready` low until frame start; P2 accepted 1 clk after it; no pair dropped.
- Stop tx after P1 -> `tx_underrun` pulses at the next frame start; line repeats P1 (macro off) or sends 0/0 (macro on).
- DATA_W=12, BITS_PER_SLOT=16, tx 12'hABC, sd looped back -> 4 trailing zeros per slot on the line and `rx_left`=12'hABC. Assert `rst_n` mid-frame -> all outputs return to reset values within the same clk.
